// File: rtl/vga_pkg.sv
// Shared VGA constants: active geometry, 12-bit RGB colours and the row bands
// used to colour spectrum bars.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [11:0] COL_RED    = 12'hF00;
    localparam logic [11:0] COL_YELLOW = 12'hFF0;
    localparam logic [11:0] COL_GREEN  = 12'h0F0;
    localparam logic [11:0] COL_BLACK  = 12'h000;

    localparam int ROW_RED_END    = 160;
    localparam int ROW_YELLOW_END = 320;

    // Top rows are the loudest part of a tall bar, so they get the warm colours.
    function automatic logic [11:0] row_colour(input logic [9:0] y);
        if (y < 10'(ROW_RED_END))
            return COL_RED;
        else if (y < 10'(ROW_YELLOW_END))
            return COL_YELLOW;
        return COL_GREEN;
    endfunction

endpackage

// File: rtl/spectrum_bar_renderer_if.sv
// Valid/ready stream carrying one (bar index, magnitude) sample per transfer.
interface spectrum_bar_renderer_if #(
    parameter int MAG_W = 16
);
    logic             bin_valid;
    logic             bin_ready;
    logic [7:0]       bin_index;
    logic [MAG_W-1:0] bin_mag;

    modport master (output bin_valid, output bin_index, output bin_mag, input bin_ready);
    modport slave  (input bin_valid, input bin_index, input bin_mag, output bin_ready);
endinterface

// File: rtl/spectrum_bar_renderer_bank.sv
// Double-buffered bar height store: writes go to the hidden bank, the display
// bank is read combinationally, and swap flips which is which.
module bar_bank #(
    parameter int NUM_BARS = 32,
    parameter int IDX_W    = 5,
    parameter int H_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [H_W-1:0]   wr_height,
    input  logic             swap,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [H_W-1:0]   rd_height,
    output logic             disp_sel
);

    logic [H_W-1:0] heights [2][NUM_BARS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_sel <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NUM_BARS; i++)
                    heights[b][i] <= '0;
        end else begin
            if (swap)
                disp_sel <= ~disp_sel;
            if (wr_en)
                heights[~disp_sel][wr_idx] <= wr_height;
        end
    end

    assign rd_height = heights[disp_sel][rd_idx];

endmodule

// File: rtl/spectrum_bar_renderer.sv
// Renders a bar-graph spectrum from streamed magnitudes, swapping height banks
// only at end of frame and keeping syncs aligned with the 2-cycle pixel pipe.
module spectrum_bar_renderer #(
    parameter int NUM_BARS  = 32,
    parameter int BAR_W     = 20,
    parameter int GAP       = 2,
    parameter int MAG_W     = 16,
    parameter int MAG_SHIFT = 7,
    parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = vga_pkg::V_ACTIVE
) (
    input  logic                    pixel_clk,
    input  logic                    reset,
    spectrum_bar_renderer_if.slave  bin,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic                    video_on,
    input  logic                    h_sync,
    input  logic                    v_sync,
    input  logic                    frame_over,
    output logic [3:0]              vga_r,
    output logic [3:0]              vga_g,
    output logic [3:0]              vga_b,
    output logic                    h_sync_out,
    output logic                    v_sync_out,
    output logic                    display_updated
);
    import vga_pkg::*;

    localparam int H_W   = 9;
    localparam int IDX_W = $clog2(NUM_BARS);
    localparam int COL_W = $clog2(BAR_W);

    function automatic logic [H_W-1:0] sat_height(input logic [MAG_W-1:0] mag);
        logic [MAG_W-1:0] scaled;
        scaled = mag >> MAG_SHIFT;
        if (scaled > MAG_W'(V_ACTIVE))
            return H_W'(V_ACTIVE);
        return scaled[H_W-1:0];
    endfunction

    logic           complete;
    logic           xfer, wr_en, swap;
    logic [H_W-1:0] rd_height;

    assign bin.bin_ready = ~complete;
    assign xfer  = bin.bin_valid && bin.bin_ready;
    assign wr_en = xfer && (bin.bin_index < 8'(NUM_BARS));
    // complete is sampled before this edge, so a last-bin transfer never swaps in the same cycle
    assign swap  = frame_over && complete;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            complete        <= 1'b0;
            display_updated <= 1'b0;
        end else begin
            display_updated <= swap;
            if (swap)
                complete <= 1'b0;
            else if (xfer && bin.bin_index == 8'(NUM_BARS-1))
                complete <= 1'b1;
        end
    end

    logic [IDX_W-1:0] bar_idx_p1;
    logic [COL_W-1:0] col_p1;
    logic [9:0]       pixel_y_p1;
    logic             vld_p1, h_sync_p1, v_sync_p1;

    bar_bank #(.NUM_BARS(NUM_BARS), .IDX_W(IDX_W), .H_W(H_W)) u_bank (
        .clk       (pixel_clk),
        .rst       (reset),
        .wr_en     (wr_en),
        .wr_idx    (bin.bin_index[IDX_W-1:0]),
        .wr_height (sat_height(bin.bin_mag)),
        .swap      (swap),
        .rd_idx    (bar_idx_p1),
        .rd_height (rd_height),
        .disp_sel  ()
    );

    // Stage 1: column tracking and alignment of row/valid/syncs
    always_ff @(posedge pixel_clk) begin
        pixel_y_p1 <= pixel_y;
        if (pixel_x == '0) begin
            bar_idx_p1 <= '0;
            col_p1     <= '0;
        end else if (video_on) begin
            if (col_p1 == COL_W'(BAR_W-1)) begin
                bar_idx_p1 <= bar_idx_p1 + IDX_W'(1);
                col_p1     <= '0;
            end else begin
                col_p1 <= col_p1 + COL_W'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            h_sync_p1 <= 1'b1;
            v_sync_p1 <= 1'b1;
        end else begin
            vld_p1    <= video_on && (pixel_x < 10'(H_ACTIVE));
            h_sync_p1 <= h_sync;
            v_sync_p1 <= v_sync;
        end
    end

    logic        lit;
    logic [11:0] rgb_p2;

    assign lit = vld_p1 && (col_p1 < COL_W'(BAR_W-GAP)) &&
                 ({1'b0, pixel_y_p1} + 11'(rd_height) >= 11'(V_ACTIVE));

    // Stage 2: height lookup, colour select, sync output
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            rgb_p2     <= COL_BLACK;
            h_sync_out <= 1'b1;
            v_sync_out <= 1'b1;
        end else begin
            rgb_p2     <= lit ? row_colour(pixel_y_p1) : COL_BLACK;
            h_sync_out <= h_sync_p1;
            v_sync_out <= v_sync_p1;
        end
    end

    assign vga_r = rgb_p2[11:8];
    assign vga_g = rgb_p2[7:4];
    assign vga_b = rgb_p2[3:0];

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Directed bench for spectrum_bar_renderer: pixel vector tables plus
// hand-written handshake, swap and reset sequences.
module tb_spectrum_bar_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, h_sync, v_sync, frame_over;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       h_sync_out, v_sync_out, display_updated;

    spectrum_bar_renderer_if #(.MAG_W(16)) bin_if ();

    spectrum_bar_renderer dut (
        .pixel_clk       (clk),
        .reset           (reset),
        .bin             (bin_if),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .video_on        (video_on),
        .h_sync          (h_sync),
        .v_sync          (v_sync),
        .frame_over      (frame_over),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .h_sync_out      (h_sync_out),
        .v_sync_out      (v_sync_out),
        .display_updated (display_updated)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        bit          vid;
        logic [11:0] exp;
        string       name;
    } pix_vec_t;

    localparam logic [11:0] RED = 12'hF00, YEL = 12'hFF0, GRN = 12'h0F0, BLK = 12'h000;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] mags [32];
    pix_vec_t    vecs [$];
    logic [11:0] rgb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send_bin(input int idx, input logic [15:0] mag, input bit fo);
        bin_if.bin_valid = 1'b1;
        bin_if.bin_index = 8'(idx);
        bin_if.bin_mag   = mag;
        frame_over       = fo;
        if (bin_if.bin_ready !== 1'b1) begin
            failures++;
            checks++;
            $display("FAIL ready_before_bin%0d actual=%b expected=1", idx, bin_if.bin_ready);
        end
        @(negedge clk);
        bin_if.bin_valid = 1'b0;
        frame_over       = 1'b0;
    endtask

    task automatic send_frame(input bit fo_on_last);
        for (int i = 0; i < 32; i++)
            send_bin(i, mags[i], fo_on_last && (i == 31));
    endtask

    task automatic pulse_frame_over();
        frame_over = 1'b1;
        @(negedge clk);
        frame_over = 1'b0;
    endtask

    // Sweep a row from column 0 so the column tracker reaches x, then read the
    // pixel two cycles after it was presented.
    task automatic get_pixel(input int x, input int y, input bit vid, output logic [11:0] pix);
        for (int i = 0; i <= x; i++) begin
            pixel_x  = 10'(i);
            pixel_y  = 10'(y);
            video_on = (i == x) ? vid : 1'b1;
            @(negedge clk);
        end
        pixel_x  = 10'd700;
        video_on = 1'b0;
        @(negedge clk);
        pix = {vga_r, vga_g, vga_b};
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            get_pixel(vecs[i].x, vecs[i].y, vecs[i].vid, rgb);
            check(vecs[i].name, rgb, vecs[i].exp);
        end
        vecs.delete();
    endtask

    initial begin
        reset = 1'b1;
        pixel_x = 10'd700; pixel_y = 10'd0; video_on = 1'b0;
        h_sync = 1'b1; v_sync = 1'b1; frame_over = 1'b0;
        bin_if.bin_valid = 1'b0; bin_if.bin_index = 8'd0; bin_if.bin_mag = 16'd0;

        // Reset defaults
        repeat (5) @(negedge clk);
        check("rst_ready", bin_if.bin_ready, 1'b1);
        check("rst_rgb", {vga_r, vga_g, vga_b}, BLK);
        check("rst_syncs", {h_sync_out, v_sync_out}, 2'b11);
        check("rst_updated", display_updated, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Sync delay: two cycles
        h_sync = 1'b0; v_sync = 1'b0;
        @(negedge clk);
        h_sync = 1'b1; v_sync = 1'b1;
        check("sync_d1", {h_sync_out, v_sync_out}, 2'b11);
        @(negedge clk);
        check("sync_d2", {h_sync_out, v_sync_out}, 2'b00);
        @(negedge clk);
        check("sync_d3", {h_sync_out, v_sync_out}, 2'b11);

        // Load bar0 saturated (480), bar3 = 120, bar5 = 1
        foreach (mags[i]) mags[i] = 16'h0000;
        mags[0] = 16'hFFFF;
        mags[3] = 16'h3C00;
        mags[5] = 16'h0080;
        send_frame(1'b0);
        check("ready_low_after_31", bin_if.bin_ready, 1'b0);
        get_pixel(0, 0, 1'b1, rgb);
        check("pre_swap_black", rgb, BLK);
        pulse_frame_over();
        check("swap1_updated", display_updated, 1'b1);
        check("swap1_ready", bin_if.bin_ready, 1'b1);
        @(negedge clk);
        check("swap1_pulse_end", display_updated, 1'b0);

        vecs.push_back('{65, 400, 1'b1, GRN, "bar3_in"});
        vecs.push_back('{65, 359, 1'b1, BLK, "bar3_above"});
        vecs.push_back('{65, 360, 1'b1, GRN, "bar3_top"});
        vecs.push_back('{78, 400, 1'b1, BLK, "bar3_gap"});
        vecs.push_back('{77, 400, 1'b1, GRN, "bar3_lastcol"});
        vecs.push_back('{0, 0, 1'b1, RED, "bar0_row0"});
        vecs.push_back('{0, 159, 1'b1, RED, "bar0_row159"});
        vecs.push_back('{0, 160, 1'b1, YEL, "bar0_row160"});
        vecs.push_back('{0, 200, 1'b1, YEL, "bar0_row200"});
        vecs.push_back('{0, 479, 1'b1, GRN, "bar0_row479"});
        vecs.push_back('{19, 479, 1'b1, BLK, "bar0_gap"});
        vecs.push_back('{100, 479, 1'b1, GRN, "bar5_h1_bottom"});
        vecs.push_back('{100, 478, 1'b1, BLK, "bar5_h1_above"});
        vecs.push_back('{20, 479, 1'b1, BLK, "bar1_h0"});
        vecs.push_back('{639, 479, 1'b1, BLK, "bar31_h0"});
        vecs.push_back('{5, 300, 1'b0, BLK, "video_off"});
        run_vecs();

        // Swap deferral: frame_over coincident with last transfer
        foreach (mags[i]) mags[i] = 16'h0000;
        mags[0] = 16'h0100;
        send_frame(1'b1);
        check("defer_no_update", display_updated, 1'b0);
        check("defer_ready_low", bin_if.bin_ready, 1'b0);
        vecs.push_back('{0, 0, 1'b1, RED, "defer_old_bar0"});
        vecs.push_back('{65, 400, 1'b1, GRN, "defer_old_bar3"});
        run_vecs();
        pulse_frame_over();
        check("defer_swap_updated", display_updated, 1'b1);
        vecs.push_back('{0, 478, 1'b1, GRN, "f2_bar0_bottom"});
        vecs.push_back('{0, 477, 1'b1, BLK, "f2_bar0_above"});
        vecs.push_back('{65, 400, 1'b1, BLK, "f2_bar3_cleared"});
        run_vecs();
        pulse_frame_over();
        check("idle_fo_no_update", display_updated, 1'b0);
        vecs.push_back('{0, 478, 1'b1, GRN, "idle_fo_retained"});
        run_vecs();

        // Out-of-range index: accepted, dropped, complete stays clear
        send_bin(40, 16'hFFFF, 1'b0);
        check("oor_ready_after", bin_if.bin_ready, 1'b1);
        foreach (mags[i]) mags[i] = 16'h0000;
        for (int i = 0; i < 32; i++)
            if (i != 8) send_bin(i, mags[i], 1'b0);
        check("oor_frame_complete", bin_if.bin_ready, 1'b0);

        // Backpressure: held valid while complete must not write
        bin_if.bin_valid = 1'b1;
        bin_if.bin_index = 8'd8;
        bin_if.bin_mag   = 16'hFFFF;
        repeat (4) @(negedge clk);
        check("bp_ready_low", bin_if.bin_ready, 1'b0);
        bin_if.bin_valid = 1'b0;
        pulse_frame_over();
        check("bp_swap_updated", display_updated, 1'b1);
        vecs.push_back('{160, 0, 1'b1, BLK, "oor_bp_bar8_top"});
        vecs.push_back('{160, 479, 1'b1, BLK, "oor_bp_bar8_bottom"});
        vecs.push_back('{0, 479, 1'b1, BLK, "f3_bar0_cleared"});
        run_vecs();

        // Reset mid-stream clears both banks and the display select
        for (int i = 0; i < 10; i++) send_bin(i, 16'hFFFF, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", bin_if.bin_ready, 1'b1);
        check("mid_rst_rgb", {vga_r, vga_g, vga_b}, BLK);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vecs.push_back('{0, 479, 1'b1, BLK, "mid_rst_bar0"});
        vecs.push_back('{65, 479, 1'b1, BLK, "mid_rst_bar3"});
        run_vecs();
        pulse_frame_over();
        check("mid_rst_no_swap", display_updated, 1'b0);
        get_pixel(0, 479, 1'b1, rgb);
        check("mid_rst_partial_dropped", rgb, BLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
